fp32_divider: RTL and testbench

FP32_DIVIDER -- requirements
Module: fp32_divider

---
 rtl/fp32_divider.sv | 200 ++++++++++++++++++++
 tb/tb_fp32_divider.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_divider.sv
// fp32_divider: multi-cycle IEEE-754 single-precision divider (restoring).
// Define FP32_DIV_ROUND_EN for round-to-nearest-even; default truncates.
module fp32_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] quotient_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        nan_o,
  output logic        infinit_o,
  output logic        div_by_zero_o,
  output logic        overflow_o,
  output logic        underflow_o
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIVIDE,
    NORM,
    DONE
  } state_t;

  state_t state, state_n;

  logic [31:0] a_r, b_r;
  logic [24:0] rem;
  logic [23:0] div;
  logic [25:0] q;
  logic [4:0]  cnt;
  logic signed [9:0] expo;

  logic [7:0] ea, eb;
  logic       sign;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign ea     = a_r[30:23];
  assign eb     = b_r[30:23];
  assign sign   = a_r[31] ^ b_r[31];
  assign a_nan  = (&ea) & (|a_r[22:0]);
  assign b_nan  = (&eb) & (|b_r[22:0]);
  assign a_inf  = (&ea) & ~(|a_r[22:0]);
  assign b_inf  = (&eb) & ~(|b_r[22:0]);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  // flag order: nan, infinit, div_by_zero, overflow, underflow
  logic        special;
  logic [31:0] spec_q;
  logic [4:0]  spec_f;

  always_comb begin
    special = 1'b1;
    spec_q  = 32'd0;
    spec_f  = 5'b00000;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_q = 32'h7FC0_0000;
      spec_f = 5'b10000;
    end else if (a_inf) begin
      spec_q = {sign, 8'hFF, 23'd0};
      spec_f = 5'b01000;
    end else if (b_inf) begin
      spec_q = {sign, 31'd0};
      spec_f = 5'b01000;
    end else if (b_zero) begin
      spec_q = {sign, 8'hFF, 23'd0};
      spec_f = 5'b00100;
    end else if (a_zero) begin
      spec_q = {sign, 31'd0};
      spec_f = 5'b00000;
    end else begin
      special = 1'b0;
    end
  end

  logic [25:0] diff;
  logic        ge;
  logic [24:0] rem_sub;

  assign diff    = {1'b0, rem} - {2'b00, div};
  assign ge      = ~diff[25];
  assign rem_sub = ge ? diff[24:0] : rem;

  logic [22:0]       frac_t;
  logic signed [9:0] exp_t;
  logic              up;
  logic [23:0]       frac_f;
  logic signed [9:0] exp_f;

  always_comb begin
    frac_t = q[25] ? q[24:2] : q[23:1];
    exp_t  = q[25] ? expo : expo - 10'sd1;
  end

`ifdef FP32_DIV_ROUND_EN
  logic sticky, guard, rest;
  assign sticky = |rem;
  assign guard  = q[25] ? q[1] : q[0];
  assign rest   = (q[25] & q[0]) | sticky;
  assign up     = guard & (rest | frac_t[0]);
`else
  logic trunc_unused;
  assign trunc_unused = q[0];
  assign up = 1'b0;
`endif

  // all-ones mantissa rounding up carries into the exponent
  assign frac_f = {1'b0, frac_t} + {23'd0, up};
  assign exp_f  = exp_t + $signed({9'd0, frac_f[23]});

  logic [31:0] nrm_q;
  logic [4:0]  nrm_f;

  always_comb begin
    nrm_q = {sign, exp_f[7:0], frac_f[22:0]};
    nrm_f = 5'b00000;
    if (exp_f >= 10'sd255) begin
      nrm_q = {sign, 8'hFF, 23'd0};
      nrm_f = 5'b00010;
    end else if (exp_f <= 10'sd0) begin
      nrm_q = {sign, 31'd0};
      nrm_f = 5'b00001;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_i) state_n = PREP;
      PREP:    state_n = special ? DONE : DIVIDE;
      DIVIDE:  if (cnt == 5'd25) state_n = NORM;
      NORM:    state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (start_i) begin
          a_r <= a_i;
          b_r <= b_i;
        end
      end
      PREP: begin
        rem  <= {2'b01, a_r[22:0]};
        div  <= {1'b1, b_r[22:0]};
        q    <= 26'd0;
        cnt  <= 5'd0;
        expo <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
      end
      DIVIDE: begin
        rem <= rem_sub << 1;
        q   <= {q[24:0], ge};
        cnt <= cnt + 5'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient_o    <= 32'd0;
      done_o        <= 1'b0;
      busy_o        <= 1'b0;
      nan_o         <= 1'b0;
      infinit_o     <= 1'b0;
      div_by_zero_o <= 1'b0;
      overflow_o    <= 1'b0;
      underflow_o   <= 1'b0;
    end else begin
      done_o <= (state_n == DONE);
      busy_o <= (state_n != IDLE);
      if (state == IDLE && start_i) begin
        {nan_o, infinit_o, div_by_zero_o,
         overflow_o, underflow_o} <= 5'b00000;
      end
      if (state == PREP && special) begin
        quotient_o <= spec_q;
        {nan_o, infinit_o, div_by_zero_o,
         overflow_o, underflow_o} <= spec_f;
      end
      if (state == NORM) begin
        quotient_o <= nrm_q;
        {nan_o, infinit_o, div_by_zero_o,
         overflow_o, underflow_o} <= nrm_f;
      end
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: directed and randomized checks of fp32_divider
// against an integer-arithmetic reference model.
module tb_fp32_divider;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] quotient_o;
  logic        done_o;
  logic        busy_o;
  logic        nan_o;
  logic        infinit_o;
  logic        div_by_zero_o;
  logic        overflow_o;
  logic        underflow_o;

  int checks = 0;
  int errors = 0;

  fp32_divider dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .quotient_o    (quotient_o),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .nan_o         (nan_o),
    .infinit_o     (infinit_o),
    .div_by_zero_o (div_by_zero_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] flags();
    return {nan_o, infinit_o, div_by_zero_o, overflow_o, underflow_o};
  endfunction

  // Reference: exact integer quotient of the scaled mantissas.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [4:0] f,
                                output int lat);
    int     ea, eb, e;
    logic   s;
    bit     an, bn, ai, bi, az, bz;
    longint m, n, num, qq, fr;
    bit     st;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    az = (ea == 0);
    bz = (eb == 0);
    lat = 2;
    f = 5'b00000;
    if (an || bn || (az && bz) || (ai && bi)) begin
      q = 32'h7FC0_0000; f = 5'b10000;
    end else if (ai) begin
      q = {s, 8'hFF, 23'd0}; f = 5'b01000;
    end else if (bi) begin
      q = {s, 31'd0}; f = 5'b01000;
    end else if (bz) begin
      q = {s, 8'hFF, 23'd0}; f = 5'b00100;
    end else if (az) begin
      q = {s, 31'd0};
    end else begin
      lat = 29;
      m   = (longint'(1) << 23) | longint'(a[22:0]);
      n   = (longint'(1) << 23) | longint'(b[22:0]);
      num = m << 25;
      qq  = num / n;
      st  = (num % n) != 0;
      e   = ea - eb + 127;
      if (qq >= (longint'(1) << 25)) fr = (qq >> 2) & 64'h7F_FFFF;
      else begin
        fr = (qq >> 1) & 64'h7F_FFFF;
        e  = e - 1;
      end
`ifdef FP32_DIV_ROUND_EN
      begin
        bit g, r;
        if (qq >= (longint'(1) << 25)) begin
          g = ((qq >> 1) & 1) != 0;
          r = ((qq & 1) != 0) || st;
        end else begin
          g = (qq & 1) != 0;
          r = st;
        end
        if (g && (r || ((fr & 1) != 0))) fr = fr + 1;
        if (fr == (longint'(1) << 23)) begin
          fr = 0;
          e  = e + 1;
        end
      end
`else
      if (st) fr = fr;
`endif
      if (e >= 255) begin
        q = {s, 8'hFF, 23'd0}; f = 5'b00010;
      end else if (e <= 0) begin
        q = {s, 31'd0}; f = 5'b00001;
      end else begin
        q = {s, e[7:0], fr[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0)      v[30:23] = 8'hFF;
    else if (k == 1) v[30:23] = 8'h00;
    else if (k == 2) v[22:0]  = 23'd0;
    else if (k < 10) v[30:23] = 8'd100 + 8'($urandom_range(0, 55));
    return v;
  endfunction

  // Caller is 1 time unit after an edge with the DUT idle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [4:0] f,
                        output int lat, output bit busy_ok);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (!busy_o) busy_ok = 1'b0;
      if (done_o) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    q = quotient_o;
    f = flags();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b1;
    a_i = 32'h40C0_0000;
    b_i = 32'h4000_0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({quotient_o, done_o, busy_o, flags()} !== 39'd0) begin
      errors++;
      $display("FAIL reset outputs got q=%h d=%b b=%b f=%b exp all 0",
               quotient_o, done_o, busy_o, flags());
    end
    rst = 1'b0;
    start_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset idle busy got %b exp 0", busy_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic [31:0] tq [10];
    logic [4:0]  tf [10];
    int          tl [10];
    logic [31:0] q;
    logic [4:0]  f;
    int          lat;
    bit          bok;
    ta[0] = 32'h40C0_0000; tb[0] = 32'h4000_0000; tq[0] = 32'h4040_0000; tf[0] = 5'b00000; tl[0] = 29;
    ta[1] = 32'h3F80_0000; tb[1] = 32'h4040_0000;
`ifdef FP32_DIV_ROUND_EN
    tq[1] = 32'h3EAA_AAAB;
`else
    tq[1] = 32'h3EAA_AAAA;
`endif
    tf[1] = 5'b00000; tl[1] = 29;
    ta[2] = 32'hBF80_0000; tb[2] = 32'h0000_0000; tq[2] = 32'hFF80_0000; tf[2] = 5'b00100; tl[2] = 2;
    ta[3] = 32'h0000_0000; tb[3] = 32'h0000_0000; tq[3] = 32'h7FC0_0000; tf[3] = 5'b10000; tl[3] = 2;
    ta[4] = 32'h7F00_0000; tb[4] = 32'h3F00_0000; tq[4] = 32'h7F80_0000; tf[4] = 5'b00010; tl[4] = 29;
    ta[5] = 32'h0080_0000; tb[5] = 32'h4000_0000; tq[5] = 32'h0000_0000; tf[5] = 5'b00001; tl[5] = 29;
    ta[6] = 32'h7F80_0000; tb[6] = 32'h3F80_0000; tq[6] = 32'h7F80_0000; tf[6] = 5'b01000; tl[6] = 2;
    ta[7] = 32'h3F80_0000; tb[7] = 32'hFF80_0000; tq[7] = 32'h8000_0000; tf[7] = 5'b01000; tl[7] = 2;
    ta[8] = 32'h0000_0000; tb[8] = 32'hC000_0000; tq[8] = 32'h8000_0000; tf[8] = 5'b00000; tl[8] = 2;
    ta[9] = 32'h7FC0_0001; tb[9] = 32'h3F80_0000; tq[9] = 32'h7FC0_0000; tf[9] = 5'b10000; tl[9] = 2;
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], q, f, lat, bok);
      checks++;
      if (q !== tq[i]) begin
        errors++;
        $display("FAIL dir%0d q got %h exp %h", i, q, tq[i]);
      end
      checks++;
      if (f !== tf[i]) begin
        errors++;
        $display("FAIL dir%0d flags got %b exp %b", i, f, tf[i]);
      end
      checks++;
      if (lat !== tl[i]) begin
        errors++;
        $display("FAIL dir%0d latency got %0d exp %0d", i, lat, tl[i]);
      end
      checks++;
      if (bok !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d busy/done got bok=%b busy=%b done=%b exp 1 0 0",
                 i, bok, busy_o, done_o);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] q;
    logic [4:0]  f;
    int          lat;
    bit          bok;
    run_op(32'hBF80_0000, 32'h0000_0000, q, f, lat, bok);
    a_i = 32'h40C0_0000;
    b_i = 32'h4000_0000;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if (flags() !== 5'b00000 || quotient_o !== 32'hFF80_0000 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL hold accept got f=%b q=%h busy=%b exp 00000 ff800000 1",
               flags(), quotient_o, busy_o);
    end
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done_o) begin
        lat = c;
        break;
      end
      if (c == 4) begin
        start_i = 1'b1;
        a_i = 32'h3F80_0000;
        b_i = 32'h4040_0000;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (lat !== 29 || quotient_o !== 32'h4040_0000) begin
      errors++;
      $display("FAIL hold busy-start got lat=%0d q=%h exp 29 40400000", lat, quotient_o);
    end
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL hold done-start got busy=%b done=%b exp 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, eq;
    logic [4:0]  f, ef;
    int          lat, el;
    bit          bok;
    for (int i = 0; i < 150; i++) begin
      a = rnd_fp();
      b = rnd_fp();
      model(a, b, eq, ef, el);
      run_op(a, b, q, f, lat, bok);
      checks++;
      if (q !== eq || f !== ef || lat !== el || bok !== 1'b1) begin
        errors++;
        $display("FAIL rand a=%h b=%h got q=%h f=%b lat=%0d bsy=%b exp q=%h f=%b lat=%0d",
                 a, b, q, f, lat, bok, eq, ef, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eq;
    logic [4:0]  ef;
    int          el;
    int          dcount;
    bit          drained;
    a_i = 32'h3F80_0000;
    b_i = 32'h4040_0000;
    model(a_i, b_i, eq, ef, el);
    dcount = 0;
    start_i = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done_o) begin
        dcount++;
        checks++;
        if ((c % 30) != 29 || quotient_o !== eq || flags() !== ef) begin
          errors++;
          $display("FAIL b2b done cyc=%0d q=%h f=%b exp cyc%%30=29 q=%h f=%b",
                   c, quotient_o, flags(), eq, ef);
        end
      end
    end
    start_i = 1'b0;
    checks++;
    if (dcount !== 3) begin
      errors++;
      $display("FAIL b2b pulses got %0d exp 3", dcount);
    end
    drained = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_o) begin
        drained = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL b2b drain got no done exp done");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] q;
    logic [4:0]  f;
    int          lat;
    bit          bok;
    int          seen;
    run_op(32'h40C0_0000, 32'h4000_0000, q, f, lat, bok);
    a_i = 32'h3F80_0000;
    b_i = 32'h4040_0000;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({quotient_o, done_o, busy_o, flags()} !== 39'd0) begin
      errors++;
      $display("FAIL midrst outputs got q=%h d=%b b=%b f=%b exp all 0",
               quotient_o, done_o, busy_o, flags());
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst start-in-reset busy got %b exp 0", busy_o);
    end
    rst = 1'b0;
    start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    checks++;
    if (seen !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst aborted got done=%0d busy=%b exp 0 0", seen, busy_o);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start_i = 1'b0;
    a_i = 32'd0;
    b_i = 32'd0;
    #1;
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
